// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus package: requester ids and outstanding-depth default.
// Imported by the arbiter and its id FIFO.
package bus_rr_arbiter_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } bus_mst_e;

  localparam int BUS_MAX_OUTST = 2;

endpackage

// File: rtl/bus_if.sv
// Simple req/gnt bus with in-order rvalid responses.
// master drives the request side, slave drives grant and response.
interface bus_if;

  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, err
  );

endinterface

// File: rtl/bus_rr_arbiter_id_fifo.sv
// id_fifo: small FIFO of requester ids for in-order response routing.
// Ports: clk_i, rst_ni, push, pop, wdata -> head, full, empty, count.
module id_fifo
  import bus_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = BUS_MAX_OUTST,
  parameter int WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEMD = 1 << PW;

  logic [WIDTH-1:0] mem_q [MEMD];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  // pointers wrap at DEPTH, not at the power-of-two storage size
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEMD; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= nxt(wr_q);
      end
      if (pop) begin
        rd_q <= nxt(rd_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter onto one bus, with in-order response routing.
// Ports: clk_i, rst_ni, m0/m1 (slave side), s (master side), proto_err_o.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = BUS_MAX_OUTST
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  bus_if.slave   m0,
  bus_if.slave   m1,
  bus_if.master  s,
  output logic   proto_err_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  bus_mst_e      prio_q;
  bus_mst_e      win;
  bus_mst_e      head;
  logic [0:0]    head_id;
  logic [CW-1:0] outst_q;
  logic          full;
  logic          empty;
  logic          any_req;
  logic          sreq;
  logic          hs;
  logic          pop;
  logic          spur;
  logic          perr_q;

  always_comb begin
    win = prio_q;
    unique case (1'b1)
      (m0.req && !m1.req): win = M0;
      (m1.req && !m0.req): win = M1;
      default: ;
    endcase
  end

  // everything facing the masters and the bus is gated by reset
  assign any_req = rst_ni && (m0.req || m1.req);
  assign sreq    = any_req && !full;
  assign hs      = sreq && s.gnt;

  assign s.req   = sreq;
  assign s.we    = any_req && ((win == M1) ? m1.we : m0.we);
  assign s.addr  = !any_req ? '0 :
                   (win == M1) ? m1.addr : m0.addr;
  assign s.wdata = !any_req ? '0 :
                   (win == M1) ? m1.wdata : m0.wdata;

  assign m0.gnt  = hs && (win == M0);
  assign m1.gnt  = hs && (win == M1);

  // a response with nothing outstanding is dropped and flagged
  assign pop     = rst_ni && s.rvalid && !empty;
  assign spur    = s.rvalid && empty;
  assign head    = bus_mst_e'(head_id);

  assign m0.rvalid = pop && (head == M0);
  assign m1.rvalid = pop && (head == M1);
  assign m0.rdata  = m0.rvalid ? s.rdata : '0;
  assign m1.rdata  = m1.rvalid ? s.rdata : '0;
  assign m0.err    = m0.rvalid && s.err;
  assign m1.err    = m1.rvalid && s.err;

  id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (1)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (hs),
    .pop    (pop),
    .wdata  (win),
    .head   (head_id),
    .full   (full),
    .empty  (empty),
    .count  (outst_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= M0;
      perr_q <= 1'b0;
    end else begin
      if (hs) begin
        prio_q <= (win == M0) ? M1 : M0;
      end
      if (spur) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign proto_err_o = perr_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter: directed steps plus random traffic
// checked against a queue-based model of arbitration and routing.
module tb_bus_rr_arbiter;
  import bus_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rq  [2];
  logic        mwe [2];
  logic [31:0] mad [2];
  logic [31:0] mwd [2];
  logic        sg, srv, serr;
  logic [31:0] srd;
  logic        perr_a, perr_b;
  int          sel;

  bus_if ma0 ();
  bus_if ma1 ();
  bus_if sa ();
  bus_if mb0 ();
  bus_if mb1 ();
  bus_if sb ();

  assign ma0.req = rq[0];  assign ma0.we = mwe[0];
  assign ma0.addr = mad[0]; assign ma0.wdata = mwd[0];
  assign ma1.req = rq[1];  assign ma1.we = mwe[1];
  assign ma1.addr = mad[1]; assign ma1.wdata = mwd[1];
  assign mb0.req = rq[0];  assign mb0.we = mwe[0];
  assign mb0.addr = mad[0]; assign mb0.wdata = mwd[0];
  assign mb1.req = rq[1];  assign mb1.we = mwe[1];
  assign mb1.addr = mad[1]; assign mb1.wdata = mwd[1];
  assign sa.gnt = sg; assign sa.rvalid = srv;
  assign sa.rdata = srd; assign sa.err = serr;
  assign sb.gnt = sg; assign sb.rvalid = srv;
  assign sb.rdata = srd; assign sb.err = serr;

  bus_rr_arbiter #(.MAX_OUTST(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .m0(ma0), .m1(ma1),
    .s(sa), .proto_err_o(perr_a)
  );

  bus_rr_arbiter #(.MAX_OUTST(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .m0(mb0), .m1(mb1),
    .s(sb), .proto_err_o(perr_b)
  );

  int tests = 0;
  int fails = 0;

  // reference model
  int  q[$];
  int  prio;
  bit  perr;
  int  cyc;
  // peripheral model
  logic [31:0] mem [16];
  int          pq_due [$];
  logic [31:0] pq_dat [$];
  logic        pq_err [$];
  int          dly;
  bit          gnt_rand;
  bit          inj;

  logic        last_g0, last_g1, last_rv0, last_rv1;
  logic        last_sreq, last_perr, last_eg0, last_eg1;
  logic [31:0] last_rd0, last_outst, last_prio;

  task automatic chk(input string tag,
                     input logic [31:0] ob,
                     input logic [31:0] ex);
    tests++;
    assert (ob === ex) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, ob, ex);
    end
  endtask

  task automatic tick();
    int M, w, dest, due;
    bit any, full, hs;
    logic o_sreq, o_swe, o_g0, o_g1;
    logic o_rv0, o_rv1, o_er0, o_er1, o_perr;
    logic [31:0] o_addr, o_wd, o_rd0, o_rd1, o_out, o_pr;
    logic [31:0] d;
    M = (sel != 0) ? 1 : 2;
    if (!rst_n) begin
      q.delete(); pq_due.delete(); pq_dat.delete();
      pq_err.delete(); prio = 0; perr = 1'b0;
    end
    sg = gnt_rand ? ($urandom % 4 != 0) : 1'b1;
    srv = inj || (pq_due.size() > 0 && pq_due[0] <= cyc);
    if (inj) begin
      srd = 32'hdead_beef; serr = 1'b1;
    end else if (srv) begin
      srd = pq_dat[0]; serr = pq_err[0];
    end else begin
      srd = $urandom; serr = 1'($urandom % 2);
    end
    @(negedge clk);
    any  = rst_n && (rq[0] || rq[1]);
    full = (q.size() == M);
    w = (rq[0] && !rq[1]) ? 0 : (rq[1] && !rq[0]) ? 1 : prio;
    hs = any && !full && sg;
    dest = (rst_n && srv && q.size() > 0) ? q[0] : -1;
    o_sreq = sel ? sb.req : sa.req;
    o_swe  = sel ? sb.we : sa.we;
    o_addr = sel ? sb.addr : sa.addr;
    o_wd   = sel ? sb.wdata : sa.wdata;
    o_g0   = sel ? mb0.gnt : ma0.gnt;
    o_g1   = sel ? mb1.gnt : ma1.gnt;
    o_rv0  = sel ? mb0.rvalid : ma0.rvalid;
    o_rv1  = sel ? mb1.rvalid : ma1.rvalid;
    o_rd0  = sel ? mb0.rdata : ma0.rdata;
    o_rd1  = sel ? mb1.rdata : ma1.rdata;
    o_er0  = sel ? mb0.err : ma0.err;
    o_er1  = sel ? mb1.err : ma1.err;
    o_perr = sel ? perr_b : perr_a;
    o_out  = sel ? 32'(u_b.outst_q) : 32'(u_a.outst_q);
    o_pr   = sel ? 32'(u_b.prio_q) : 32'(u_a.prio_q);
    chk("s_req", o_sreq, any && !full);
    chk("m0_gnt", o_g0, hs && w == 0);
    chk("m1_gnt", o_g1, hs && w == 1);
    chk("s_we", o_swe, any ? mwe[w] : 1'b0);
    chk("s_addr", o_addr, any ? mad[w] : 32'h0);
    chk("s_wdata", o_wd, any ? mwd[w] : 32'h0);
    chk("m0_rvalid", o_rv0, dest == 0);
    chk("m1_rvalid", o_rv1, dest == 1);
    chk("m0_rdata", o_rd0, dest == 0 ? srd : 32'h0);
    chk("m1_rdata", o_rd1, dest == 1 ? srd : 32'h0);
    chk("m0_err", o_er0, dest == 0 ? serr : 1'b0);
    chk("m1_err", o_er1, dest == 1 ? serr : 1'b0);
    chk("proto_err", o_perr, perr);
    chk("outst", o_out, q.size());
    chk("prio", o_pr, prio);
    last_g0 = o_g0; last_g1 = o_g1;
    last_rv0 = o_rv0; last_rv1 = o_rv1;
    last_rd0 = o_rd0; last_sreq = o_sreq;
    last_perr = o_perr; last_outst = o_out;
    last_prio = o_pr;
    last_eg0 = hs && w == 0; last_eg1 = hs && w == 1;
    @(posedge clk);
    if (rst_n) begin
      if (srv && q.size() > 0) begin
        void'(q.pop_front());
        if (!inj) begin
          void'(pq_due.pop_front());
          void'(pq_dat.pop_front());
          void'(pq_err.pop_front());
        end
      end else if (srv) begin
        perr = 1'b1;
      end
      if (hs) begin
        q.push_back(w);
        prio = 1 - w;
        if (mwe[w]) begin
          mem[mad[w][3:0]] = mwd[w];
          d = 32'h0;
        end else begin
          d = mem[mad[w][3:0]];
        end
        due = cyc + dly;
        if (pq_due.size() > 0 && due <= pq_due[$])
          due = pq_due[$] + 1;
        pq_due.push_back(due);
        pq_dat.push_back(d);
        pq_err.push_back(1'($urandom % 8 == 0));
      end
    end
    cyc++;
    #1;
  endtask

  task automatic new_txn(input int k);
    mwe[k] = 1'($urandom % 2);
    mad[k] = 32'($urandom % 16);
    mwd[k] = $urandom;
  endtask

  task automatic rand_stim();
    if (!rq[0] || last_eg0) begin
      rq[0] = 1'($urandom % 2); new_txn(0);
    end
    if (!rq[1] || last_eg1) begin
      rq[1] = 1'($urandom % 2); new_txn(1);
    end
    dly = $urandom_range(1, 3);
  endtask

  initial begin
    int prev, ngr;
    sel = 0; rst_n = 1'b0; gnt_rand = 1'b0; inj = 1'b0;
    dly = 1; cyc = 0; prio = 0; perr = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      rq[k] = 1'b0; mwe[k] = 1'b0; mad[k] = '0; mwd[k] = '0;
    end
    tick(); tick();
    chk("rst_sreq", last_sreq, 1'b0);
    chk("rst_prio", last_prio, 32'(M0));
    rst_n = 1'b1;
    tick();

    // single requester: write 5 then read it back
    rq[0] = 1'b1; mwe[0] = 1'b1; mad[0] = 32'h0; mwd[0] = 32'h5;
    tick();
    chk("single_gnt", last_g0, 1'b1);
    rq[0] = 1'b0;
    tick();
    chk("single_rvalid", last_rv0, 1'b1);
    rq[0] = 1'b1; mwe[0] = 1'b0;
    tick();
    rq[0] = 1'b0;
    tick();
    chk("readback_rvalid", last_rv0, 1'b1);
    chk("readback_rdata", last_rd0, 32'h5);
    tick();

    // contention straight out of reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rq[0] = 1'b1; rq[1] = 1'b1; new_txn(0); new_txn(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("alt_gnt", {last_g1, last_g0},
          (i % 2 != 0) ? 32'd2 : 32'd1);
      new_txn(0); new_txn(1);
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    tick(); tick();

    // simultaneous push and pop
    rq[0] = 1'b1; new_txn(0);
    tick();
    rq[0] = 1'b0; rq[1] = 1'b1; new_txn(1);
    tick();
    chk("pp_gnt1", last_g1, 1'b1);
    chk("pp_rv0", last_rv0, 1'b1);
    rq[1] = 1'b0;
    tick();
    chk("pp_outst_after", last_outst, 32'd1);
    chk("pp_rv1", last_rv1, 1'b1);
    tick();

    // spurious response, then reset mid-burst
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("inj_no_rv", {last_rv1, last_rv0}, 32'd0);
    tick();
    chk("perr_set", last_perr, 1'b1);
    rq[0] = 1'b1; rq[1] = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("rst_perr", last_perr, 1'b0);
    chk("rst_sreq_mid", last_sreq, 1'b0);
    chk("rst_prio_mid", last_prio, 32'(M0));
    rst_n = 1'b1; rq[0] = 1'b0; rq[1] = 1'b0;
    tick();

    // random traffic, depth 2
    gnt_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rand_stim();
      tick();
    end

    // backpressure, depth 1, 3-cycle response delay
    sel = 1; rst_n = 1'b0; gnt_rand = 1'b0; dly = 3;
    rq[0] = 1'b0; rq[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rq[0] = 1'b1; rq[1] = 1'b1;
    prev = -1; ngr = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (last_g0 || last_g1) begin
        if (prev >= 0) chk("bp_gap", 32'(cyc - prev), 32'd4);
        prev = cyc; ngr++;
      end
      new_txn(0); new_txn(1);
    end
    chk("bp_grants", 32'(ngr), 32'd4);

    // random traffic, depth 1
    rq[0] = 1'b0; rq[1] = 1'b0; gnt_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_stim();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
